// File: rtl/mask_pixel_feeder.sv
// Luma-window mask front end: RGB565 stream in, (x, y, valid) per masked pixel out,
// plus end-of-frame tabulate pulse with the frame's masked-pixel count.
module mask_pixel_feeder #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pixel_valid_in,
    input  logic [15:0] pixel_in,
    input  logic        sof_in,
    input  logic [7:0]  thr_lo_in,
    input  logic [7:0]  thr_hi_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        tabulate_out,
    output logic [20:0] count_out,
    output logic        abort_out
);

    // state    | meaning
    // WAIT_SOF | idle between frames; non-SOF pixels are dropped
    // ACTIVE   | inside a frame; every valid pixel gets the next coordinate
    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

    state_t      state;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [7:0]  thr_lo_q;
    logic [7:0]  thr_hi_q;

    logic        accept;
    logic [10:0] cur_x;
    logic [9:0]  cur_y;
    logic        cur_last;
    logic [7:0]  cur_lo;
    logic [7:0]  cur_hi;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;

    always_comb begin
        accept   = pixel_valid_in && (sof_in || (state == ACTIVE));
        cur_x    = sof_in ? 11'd0 : x_cnt;
        cur_y    = sof_in ? 10'd0 : y_cnt;
        cur_last = (cur_x == X_LAST) && (cur_y == Y_LAST);
        cur_lo   = sof_in ? thr_lo_in : thr_lo_q;
        cur_hi   = sof_in ? thr_hi_in : thr_hi_q;
        r8       = {pixel_in[15:11], pixel_in[15:13]};
        g8       = {pixel_in[10:5], pixel_in[10:9]};
        b8       = {pixel_in[4:0], pixel_in[4:2]};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= WAIT_SOF;
            x_cnt     <= 11'd0;
            y_cnt     <= 10'd0;
            thr_lo_q  <= 8'd0;
            thr_hi_q  <= 8'd255;
            abort_out <= 1'b0;
        end else begin
            abort_out <= accept && sof_in && (state == ACTIVE);
            if (accept) begin
                if (sof_in) begin
                    thr_lo_q <= thr_lo_in;
                    thr_hi_q <= thr_hi_in;
                end
                if (cur_last) begin
                    state <= WAIT_SOF;
                    x_cnt <= 11'd0;
                    y_cnt <= 10'd0;
                end else begin
                    state <= ACTIVE;
                    if (cur_x == X_LAST) begin
                        x_cnt <= 11'd0;
                        y_cnt <= cur_y + 10'd1;
                    end else begin
                        x_cnt <= cur_x + 11'd1;
                        y_cnt <= cur_y;
                    end
                end
            end
        end
    end

    // Thresholds travel with each pixel so that pixels of an aborted frame
    // still in flight are judged against their own frame's window.
    logic        s1_valid, s1_sof, s1_last;
    logic [10:0] s1_x;
    logic [9:0]  s1_y;
    logic [7:0]  s1_lo, s1_hi;
    logic [15:0] s1_pr, s1_pg, s1_pb;

    logic        s2_valid, s2_sof, s2_last;
    logic [10:0] s2_x;
    logic [9:0]  s2_y;
    logic [7:0]  s2_lo, s2_hi;
    logic [7:0]  s2_luma;

    logic        s3_last;
    logic [20:0] frame_cnt;
    logic        s2_masked;

    always_comb begin
        s2_masked = s2_valid && (s2_lo <= s2_luma) && (s2_luma <= s2_hi);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid     <= 1'b0;
            s1_sof       <= 1'b0;
            s1_last      <= 1'b0;
            s1_x         <= 11'd0;
            s1_y         <= 10'd0;
            s1_lo        <= 8'd0;
            s1_hi        <= 8'd0;
            s1_pr        <= 16'd0;
            s1_pg        <= 16'd0;
            s1_pb        <= 16'd0;
            s2_valid     <= 1'b0;
            s2_sof       <= 1'b0;
            s2_last      <= 1'b0;
            s2_x         <= 11'd0;
            s2_y         <= 10'd0;
            s2_lo        <= 8'd0;
            s2_hi        <= 8'd0;
            s2_luma      <= 8'd0;
            valid_out    <= 1'b0;
            x_out        <= 11'd0;
            y_out        <= 10'd0;
            s3_last      <= 1'b0;
            frame_cnt    <= 21'd0;
            tabulate_out <= 1'b0;
            count_out    <= 21'd0;
        end else begin
            s1_valid <= accept;
            s1_sof   <= accept && sof_in;
            s1_last  <= accept && cur_last;
            s1_x     <= cur_x;
            s1_y     <= cur_y;
            s1_lo    <= cur_lo;
            s1_hi    <= cur_hi;
            s1_pr    <= 16'(r8) * 16'd77;
            s1_pg    <= 16'(g8) * 16'd150;
            s1_pb    <= 16'(b8) * 16'd29;

            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_last  <= s1_last;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            s2_lo    <= s1_lo;
            s2_hi    <= s1_hi;
            s2_luma  <= 8'((s1_pr + s1_pg + s1_pb) >> 8);

            valid_out <= s2_masked;
            x_out     <= s2_x;
            y_out     <= s2_y;
            s3_last   <= s2_valid && s2_last;
            // The SOF slot restarts the count as it passes, so an aborted frame's
            // partial count is simply discarded.
            if (s2_valid)
                frame_cnt <= (s2_sof ? 21'd0 : frame_cnt) + 21'(s2_masked);

            tabulate_out <= s3_last;
            if (s3_last)
                count_out <= frame_cnt;
        end
    end

endmodule

// File: doc/mask_pixel_feeder.md
# mask_pixel_feeder

Upstream stage of the centroid tracker. Consumes the raw RGB565 camera pixel stream and generates pixel coordinates internally. Thresholds each pixel's luma against a per-frame window and emits `(x, y, valid)` for in-window pixels, plus a one-cycle `tabulate_out` pulse once the last pixel of a complete frame has left the pipeline. Its outputs connect directly to the centroid stage's `x_in / y_in / valid_in / tabulate_in`.

## Interface
- `H_ACTIVE`, default 1280: active pixels per line; x wraps at `H_ACTIVE-1`.
- `V_ACTIVE`, default 720: active lines per frame; the frame ends at `y = V_ACTIVE-1`.
- `clk_in` input 1: single clock; all logic is on its rising edge.
- `rst_in` input 1: asynchronous, active-low reset.
- `pixel_valid_in` input 1: `pixel_in` carries a pixel this cycle.
- `pixel_in` input 16: RGB565 pixel, R in [15:11], G in [10:5], B in [4:0].
- `sof_in` input 1: start of frame; qualified by `pixel_valid_in`; marks the pixel at (0,0).
- `thr_lo_in` input 8: inclusive luma lower bound; sampled on the SOF pixel.
- `thr_hi_in` input 8: inclusive luma upper bound; sampled on the SOF pixel.
- `x_out` output 11: x coordinate of the emitted pixel.
- `y_out` output 10: y coordinate of the emitted pixel.
- `valid_out` output 1: the emitted pixel is inside the luma window.
- `tabulate_out` output 1: one-cycle pulse marking the end of a complete frame.
- `count_out` output 21: number of masked pixels in the last complete frame; updated on `tabulate_out`.
- `abort_out` output 1: one-cycle pulse when a frame is abandoned by an early SOF.

## Operation
- Control FSM has two states: `WAIT_SOF` (reset state) and `ACTIVE`.
- **WAIT_SOF**
  - Pixels without `sof_in` are dropped and never enter the pipeline.
  - A valid SOF pixel is accepted at (0,0), latches `thr_lo_in` / `thr_hi_in`, clears the frame mask counter, and moves the FSM to `ACTIVE`.
- **ACTIVE**
  - Each valid pixel takes the current (x_cnt, y_cnt).
  - x_cnt increments; at `H_ACTIVE-1` it wraps to 0 and y_cnt increments.
  - The pixel at (`H_ACTIVE-1`, `V_ACTIVE-1`) is tagged *last*. The FSM returns to `WAIT_SOF` and counters return to 0.
- **SOF while ACTIVE** (mid-frame)
  - Current frame is aborted: `abort_out` pulses, no tabulate is issued for it, and `count_out` is left unchanged.
  - The SOF pixel starts a new frame at (0,0) with freshly latched thresholds; the FSM stays `ACTIVE`.
  - Pixels of the aborted frame already in the pipeline still emit `valid_out` normally.
- Cycles with `pixel_valid_in = 0` are bubbles: counters hold, and a valid=0 slot flows through the pipeline.
- **Luma**
  - Expand each channel to 8 bits: R8 = {r5, r5[4:2]}, G8 = {g6, g6[5:4]}, B8 = {b5, b5[4:2]}.
  - Y = (77·R8 + 150·G8 + 29·B8) >> 8, computed in a 16-bit unsigned sum; the result range is 0..255.
- **Mask**: masked = `thr_lo ≤ Y ≤ thr_hi`, unsigned. If `thr_lo > thr_hi`, no pixel in that frame is masked.
- **Outputs per pixel**: `valid_out` = pixel valid AND masked. `x_out` / `y_out` are driven for every pipeline slot; they are meaningful only when `valid_out` = 1.
- **Frame mask count**
  - The counter increments per emitted `valid_out`; it is 21 bits and covers the full frame size without overflow.
  - On a *last*-tagged pixel, the counter value plus that pixel's own contribution is loaded into `count_out` on the tabulate cycle.

## Timing
- Pipeline is 3 stages with no backpressure; it advances every cycle.
  - S1: channel expansion and the three products.
  - S2: sum and shift.
  - S3: compare and register outputs.
- Latency is 3 cycles from the input pixel to `valid_out` / `x_out` / `y_out`.
- `tabulate_out` asserts exactly 1 cycle after the output cycle of the *last* pixel (4 cycles after it entered), for 1 cycle, with `valid_out = 0` in the same cycle.
- `abort_out` asserts 1 cycle after the aborting SOF pixel is accepted.
- On a mid-frame abort, any tabulate already in flight for a previously completed frame still fires.
- Reset: all outputs go to 0 immediately (asynchronous), the FSM enters `WAIT_SOF`, counters and pipeline valid bits clear, and latched thresholds reset to lo = 0, hi = 255.
- Reset asserted mid-frame discards all in-flight pixels; no tabulate or abort is issued.
- Back-to-back frames are supported: an SOF on the cycle immediately after the *last* pixel is accepted without loss.

## Test plan
- **Luma check** (`H_ACTIVE`=4, `V_ACTIVE`=3, window lo=0, hi=255): pixels FFFF, F800, 07E0, 001F give Y = 255, 76, 149, 28. All four emit `valid_out` at (0..3, 0), 3 cycles after input.
- **Full-frame tabulate** (window lo=100, hi=200; 4×3 frame of 07E0 with one FFFF at (2,1)): 11 valid outputs, with (2,1) absent. `tabulate_out` pulses once, 1 cycle after the (3,2) output cycle, and `count_out` = 11.
- **Bubbles and pre-SOF drop**: send 5 pixels with no SOF, then a frame with `pixel_valid_in` toggling every other cycle. The first 5 pixels produce no output; coordinates are contiguous 0..3 / 0..2 and the tabulate count is correct.
- **Mid-frame abort**: SOF at pixel 6 of a frame. `abort_out` pulses once, `count_out` is unchanged, the new frame starts at (0,0), and a later tabulate reflects only the new frame.
- **Inverted window** (lo=200, hi=50): a full frame gives no `valid_out`, `tabulate_out` pulses, and `count_out` = 0.
- **Async reset**: assert `rst_in` low mid-frame between clock edges. All outputs read 0 before the next edge; after release, a pixel without SOF is dropped.
